// File: rtl/remap_seq.sv
// Frame sequencer for the remap core: walks the output raster in scan order and issues
// one coordinate request per pixel. Issue is paced by valid/ready, a credit limit on
// outstanding requests and optional blanking after each line. Completions are counted
// back, and done pulses once the frame (or an aborted frame) has fully drained.
module remap_seq #(
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int LINE_GAP        = 0,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] cfg_width,
    input  logic [DATA_WIDTH-1:0] cfg_height,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  cfg_err,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [DATA_WIDTH-1:0] req_x,
    output logic [DATA_WIDTH-1:0] req_y,
    output logic                  req_sof,
    output logic                  req_eol,
    input  logic                  cmpl_valid,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  err_underflow
);

    // Gap counter is at least one bit wide so a zero LINE_GAP still elaborates cleanly.
    localparam int GAP_W = (LINE_GAP > 0) ? $clog2(LINE_GAP + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_next;

    logic [DATA_WIDTH-1:0] width_q;
    logic [DATA_WIDTH-1:0] height_q;
    logic [DATA_WIDTH-1:0] x_q;
    logic [DATA_WIDTH-1:0] y_q;
    logic [GAP_W-1:0]      gap_q;
    logic [CNT_W-1:0]      out_q;
    logic [CNT_W-1:0]      out_next;

    logic                  done_q;
    logic                  aborted_q;
    logic                  cfg_err_q;
    logic                  underflow_q;

    logic                  cfg_ok;
    logic                  start_ok;
    logic                  start_bad;
    logic                  credit_ok;
    logic                  handshake;
    logic                  last_x;
    logic                  last_y;
    logic                  last_hs;
    logic                  cmpl_ok;
    logic                  abort_take;
    logic                  drain_exit;

    assign cfg_ok     = (cfg_width != '0) && (cfg_height != '0);
    assign start_ok   = (state_q == IDLE) && start && !abort && cfg_ok;
    assign start_bad  = (state_q == IDLE) && start && !cfg_ok;
    assign credit_ok  = out_q < CNT_W'(MAX_OUTSTANDING);
    assign req_valid  = (state_q == RUN) && (gap_q == '0) && credit_ok;
    assign handshake  = req_valid && req_ready;
    assign last_x     = x_q == (width_q - DATA_WIDTH'(1));
    assign last_y     = y_q == (height_q - DATA_WIDTH'(1));
    assign last_hs    = handshake && last_x && last_y;
    assign cmpl_ok    = cmpl_valid && (out_q != '0);
    assign abort_take = (state_q == RUN) && abort && !last_hs;
    assign drain_exit = (state_q == DRAIN) && (out_next == '0);

    assign busy          = state_q != IDLE;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign cfg_err       = cfg_err_q;
    assign err_underflow = underflow_q;
    assign outstanding   = out_q;
    assign req_x         = x_q;
    assign req_y         = y_q;
    assign req_sof       = (state_q == RUN) && (x_q == '0) && (y_q == '0);
    assign req_eol       = (state_q == RUN) && last_x;

    // Credit count after this cycle; a completion with nothing outstanding is discarded.
    always_comb begin
        out_next = out_q;
        if (handshake && !cmpl_ok) begin
            out_next = out_q + CNT_W'(1);
        end else if (!handshake && cmpl_ok) begin
            out_next = out_q - CNT_W'(1);
        end
    end

    // Next-state logic: the last handshake or an abort ends issue; drain waits for credits.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (last_hs || abort) state_next = DRAIN;
            DRAIN:   if (out_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Latch the frame geometry so mid-frame cfg changes are invisible to the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q  <= '0;
            height_q <= '0;
        end else if (start_ok) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
        end
    end

    // Raster position; only moves on a handshake so a pending request stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (start_ok) begin
            x_q <= '0;
            y_q <= '0;
        end else if (handshake) begin
            if (last_x) begin
                x_q <= '0;
                y_q <= y_q + DATA_WIDTH'(1);
            end else begin
                x_q <= x_q + DATA_WIDTH'(1);
            end
        end
    end

    // Blanking after each end-of-line handshake, counted down one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else if (start_ok) begin
            gap_q <= '0;
        end else if ((LINE_GAP > 0) && handshake && last_x) begin
            gap_q <= GAP_W'(LINE_GAP);
        end else if (gap_q != '0) begin
            gap_q <= gap_q - GAP_W'(1);
        end
    end

    // Outstanding request counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_next;
        end
    end

    // Status pulses and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            done_q    <= drain_exit;
            cfg_err_q <= start_bad;
            if (start_ok) begin
                aborted_q <= 1'b0;
            end else if (abort_take) begin
                aborted_q <= 1'b1;
            end
            if (cmpl_valid && (out_q == '0)) begin
                underflow_q <= 1'b1;
            end else if (start_ok) begin
                underflow_q <= 1'b0;
            end
        end
    end

endmodule
